// File: rtl/button_debounce_multi.sv
// button_debounce_multi
//   N_BTN independent button channels. Each channel has a 2-flop synchroniser,
//   polarity normalisation and a four-state debounce FSM. Per channel it
//   produces a clean level, one-cycle press/release/long-press strobes and a
//   toggle register. Every output is a registered signal synchronous to clk.
//
//   Optional feature macro: AUTOREPEAT_EN
//     defined   : after long_press, press (and toggle) re-fire every REP_CYC
//                 cycles while the channel stays held.
//     undefined : no repeat logic; REPEAT_MS only affects the counter width.
//
//   The release strobe port is called release_pulse because "release" is a
//   reserved word in SystemVerilog.
module button_debounce_multi #(
  parameter int N_BTN       = 4,
  parameter int CLK_HZ      = 12_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int ACTIVE_LOW  = 1,
  parameter int REPEAT_MS   = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] toggle
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYC = CLK_HZ / 1000 * LONG_MS;
  localparam int REP_CYC  = CLK_HZ / 1000 * REPEAT_MS;
  localparam int MAX_CYC  = max3(DB_CYC, LONG_CYC, REP_CYC);
  localparam int CW       = $clog2(MAX_CYC + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CNT_ONE   = cnt_t'(1);
  localparam cnt_t DB_LAST   = cnt_t'(DB_CYC - 1);
  localparam cnt_t LONG_TOP  = cnt_t'(LONG_CYC);
  localparam cnt_t LONG_LAST = cnt_t'(LONG_CYC - 1);
`ifdef AUTOREPEAT_EN
  localparam cnt_t REP_LAST  = cnt_t'(REP_CYC - 1);
`endif

  // Pin level that means "not pressed"; the synchroniser idles here.
  localparam logic IDLE_PIN = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    REL   = 2'd0,
    CHK_P = 2'd1,
    HELD  = 2'd2,
    CHK_R = 2'd3
  } state_t;

  // Counter increment that sticks at top instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v, input cnt_t top);
    return (v == top) ? v : v + CNT_ONE;
  endfunction

  // Elaboration-time parameter range checks.
  if (N_BTN < 1 || N_BTN > 32) begin : g_bad_n_btn
    $error("button_debounce_multi: N_BTN must be in 1..32");
  end
  if (DB_CYC < 2) begin : g_bad_db_cyc
    $error("button_debounce_multi: DB_CYC must be >= 2");
  end
  if (LONG_CYC <= 0) begin : g_bad_long_cyc
    $error("button_debounce_multi: LONG_CYC must be > 0");
  end
  if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_active_low
    $error("button_debounce_multi: ACTIVE_LOW must be 0 or 1");
  end
`ifdef AUTOREPEAT_EN
  if (REP_CYC <= 0) begin : g_bad_rep_cyc
    $error("button_debounce_multi: REP_CYC must be > 0 with auto-repeat");
  end
`endif

  logic [N_BTN-1:0] sync_p0;
  logic [N_BTN-1:0] sync_p1;
  logic [N_BTN-1:0] pressed_s;

  // ---- stage p0/p1: two-flop synchroniser, reset to the released pin level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= {N_BTN{IDLE_PIN}};
      sync_p1 <= {N_BTN{IDLE_PIN}};
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- polarity normalisation: 1 = pressed regardless of pin wiring
  assign pressed_s = sync_p1 ^ {N_BTN{IDLE_PIN}};

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic   s_ch;
    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    cnt_t   hold_q, hold_d;
    logic   level_q, level_d;
    logic   press_q, press_d;
    logic   release_q, release_d;
    logic   long_q, long_d;
    logic   toggle_q, toggle_d;
`ifdef AUTOREPEAT_EN
    cnt_t   rep_q, rep_d;
`endif

    assign s_ch = pressed_s[i];

    // Debounce FSM next state, counters and registered-output next values
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      toggle_d  = toggle_q;
`ifdef AUTOREPEAT_EN
      rep_d     = rep_q;
`endif
      case (state_q)
        REL: begin
          hold_d = '0;
          if (s_ch) begin
            state_d = CHK_P;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        CHK_P: begin
          if (!s_ch) begin
            // A bounce throws away the partial qualification.
            state_d = REL;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d  = HELD;
            cnt_d    = '0;
            hold_d   = '0;
            level_d  = 1'b1;
            press_d  = 1'b1;
            toggle_d = ~toggle_q;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          hold_d = sat_inc(hold_q, LONG_TOP);
          long_d = (hold_q == LONG_LAST);
          if (!s_ch) begin
            state_d = CHK_R;
            cnt_d   = CNT_ONE;
          end
`ifdef AUTOREPEAT_EN
          else if (hold_q == LONG_TOP) begin
            // Repeats run only once the hold counter has saturated,
            // i.e. after long_press has already fired.
            if (rep_q == REP_LAST) begin
              rep_d    = '0;
              press_d  = 1'b1;
              toggle_d = ~toggle_q;
            end else begin
              rep_d = rep_q + CNT_ONE;
            end
          end
`endif
        end
        CHK_R: begin
          // Hold time keeps running so a release bounce cannot re-arm long_press.
          hold_d = sat_inc(hold_q, LONG_TOP);
          long_d = (hold_q == LONG_LAST);
          if (s_ch) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d   = REL;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = REL;
          cnt_d   = '0;
          hold_d  = '0;
        end
      endcase
`ifdef AUTOREPEAT_EN
      if (state_d != HELD) begin
        rep_d = '0;
      end
`endif
    end

    // ---- stage p2: FSM state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= REL;
        cnt_q     <= '0;
        hold_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        toggle_q  <= 1'b0;
`ifdef AUTOREPEAT_EN
        rep_q     <= '0;
`endif
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        hold_q    <= hold_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        toggle_q  <= toggle_d;
`ifdef AUTOREPEAT_EN
        rep_q     <= rep_d;
`endif
      end
    end

    assign level[i]         = level_q;
    assign press[i]         = press_q;
    assign release_pulse[i] = release_q;
    assign long_press[i]    = long_q;
    assign toggle[i]        = toggle_q;
  end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Testbench for button_debounce_multi: directed scenarios plus randomized pin
// activity, checked by a queue-based scoreboard against a run-length model.
`timescale 1ns/1ps
module tb_button_debounce_multi;
  localparam int N       = 4;
  localparam int CLK_HZ  = 10_000;
  localparam int DEB_MS  = 1;
  localparam int LONG_MS = 5;
  localparam int REP_MS  = 2;
  localparam int DB      = CLK_HZ / 1000 * DEB_MS;   // 10
  localparam int LC      = CLK_HZ / 1000 * LONG_MS;  // 50
  localparam int RC      = CLK_HZ / 1000 * REP_MS;   // 20

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] btn_raw = '1;
  logic [N-1:0] level, press, release_pulse, long_press, toggle;

  button_debounce_multi #(
    .N_BTN(N), .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEB_MS), .LONG_MS(LONG_MS),
    .ACTIVE_LOW(1), .REPEAT_MS(REP_MS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .level(level), .press(press),
    .release_pulse(release_pulse), .long_press(long_press), .toggle(toggle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind bits: [0] press, [1] release, [2] long_press
  typedef struct packed {
    int         cyc;
    logic [2:0] kind;
    logic       lvl;
    logic       tgl;
  } ev_t;

  ev_t exp_q[N][$];

  // Reference model: per channel, the run length of the current pressed value.
  bit m_lvl[N];
  bit m_tgl[N];
  bit m_run_val[N];
  int m_run_len[N];
  int m_press_e[N];
  int m_anchor[N];

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_lvl[c]     = 1'b0;
      m_tgl[c]     = 1'b0;
      m_run_val[c] = 1'b0;
      m_run_len[c] = 0;
      m_press_e[c] = 0;
      m_anchor[c]  = -1;
      exp_q[c].delete();
    end
  endfunction

  // Apply one pressed/not-pressed sample seen by the debouncer at clock edge e.
  // Level flips after DB consecutive samples of the opposite value; long press
  // is LC edges after the press edge while still held.
  function automatic void model_edge(input int c, input int e, input bit s);
    logic [2:0] k;
    ev_t        ev;
    k = 3'b000;
    if (s == m_run_val[c]) m_run_len[c]++;
    else begin
      m_run_val[c] = s;
      m_run_len[c] = 1;
    end
    if (m_lvl[c] && (e - m_press_e[c] == LC)) begin
      k[2] = 1'b1;
      m_anchor[c] = e;
    end
    if (!m_lvl[c] && s && m_run_len[c] == DB) begin
      m_lvl[c]     = 1'b1;
      m_tgl[c]     = ~m_tgl[c];
      k[0]         = 1'b1;
      m_press_e[c] = e;
      m_anchor[c]  = -1;
    end else if (m_lvl[c] && !s) begin
      if (m_anchor[c] >= 0) m_anchor[c] = e + 1;
      if (m_run_len[c] == DB) begin
        m_lvl[c] = 1'b0;
        k[1]     = 1'b1;
      end
    end
`ifdef AUTOREPEAT_EN
    else if (m_lvl[c] && s && m_anchor[c] >= 0 && e > m_anchor[c] &&
             ((e - m_anchor[c]) % RC == 0)) begin
      k[0]     = 1'b1;
      m_tgl[c] = ~m_tgl[c];
    end
`endif
    if (k != 3'b000) begin
      ev.cyc  = e;
      ev.kind = k;
      ev.lvl  = m_lvl[c];
      ev.tgl  = m_tgl[c];
      exp_q[c].push_back(ev);
    end
  endfunction

  // Pin value driven at the negedge after edge n is first sampled at n+1 and
  // reaches the debouncer's decision at edge n+3.
  task automatic drive(input logic [N-1:0] p);
    @(negedge clk);
    btn_raw = p;
    if (rst_n) begin
      for (int c = 0; c < N; c++) model_edge(c, cyc + 3, ~p[c]);
    end
  endtask

  task automatic hold(input logic [N-1:0] p, input int n);
    for (int k = 0; k < n; k++) drive(p);
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Scoreboard monitor: every output strobe must match the queued expectation.
  always @(negedge clk) begin : monitor
    ev_t        ev;
    logic [2:0] act;
    if (done) begin
      for (int c = 0; c < N; c++) begin
        checks++;
        if (exp_q[c].size() != 0) begin
          errors++;
          $display("FAIL leftover ch%0d: got %0d unmatched events, required 0", c, exp_q[c].size());
        end
        checks++;
        if (level[c] !== m_lvl[c] || toggle[c] !== m_tgl[c]) begin
          errors++;
          $display("FAIL final_state ch%0d: got level %b toggle %b, required level %b toggle %b",
                   c, level[c], toggle[c], m_lvl[c], m_tgl[c]);
        end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end else if (!rst_n) begin
      checks++;
      if ({level, press, release_pulse, long_press, toggle} !== '0) begin
        errors++;
        $display("FAIL reset_state cyc %0d: got lvl %b prs %b rel %b lng %b tgl %b, required all 0",
                 cyc, level, press, release_pulse, long_press, toggle);
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        act = {long_press[c], release_pulse[c], press[c]};
        while (exp_q[c].size() > 0 && exp_q[c][0].cyc < cyc) begin
          ev = exp_q[c].pop_front();
          checks++;
          errors++;
          $display("FAIL missed_event ch%0d cyc %0d: got nothing, required kind %b", c, ev.cyc, ev.kind);
        end
        if (exp_q[c].size() > 0 && exp_q[c][0].cyc == cyc) begin
          ev = exp_q[c].pop_front();
          checks++;
          if (act !== ev.kind || level[c] !== ev.lvl || toggle[c] !== ev.tgl) begin
            errors++;
            $display("FAIL event ch%0d cyc %0d: got kind %b level %b toggle %b, required kind %b level %b toggle %b",
                     c, cyc, act, level[c], toggle[c], ev.kind, ev.lvl, ev.tgl);
          end
        end else if (act != 3'b000) begin
          checks++;
          errors++;
          $display("FAIL spurious ch%0d cyc %0d: got kind %b, required 000", c, cyc, act);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [N-1:0] cur;
    int           left[N];
    model_reset();
    #1 rst_n = 1'b0;
    hold(4'hF, 4);
    release_reset();
    hold(4'hF, 20);

    // clean press on channel 0, long enough for long_press
    hold(4'hE, 100);
    hold(4'hF, 40);

    // bouncing channel 1, then a stable press
    for (int k = 0; k < 10; k++) hold((k % 2 == 0) ? 4'hD : 4'hF, 3);
    hold(4'hD, 80);
    hold(4'hF, 40);

    // short glitch on channel 2
    hold(4'hB, 8);
    hold(4'hF, 30);

    // simultaneous press on channels 0 and 3
    hold(4'h6, 30);
    hold(4'hF, 40);

    // reset while channel 0 is mid-qualification, pin kept low across reset
    hold(4'hE, 7);
    assert_reset();
    hold(4'hE, 4);
    release_reset();
    hold(4'hE, 30);
    hold(4'hF, 40);

    // long hold on channel 0 (auto-repeat territory when enabled)
    hold(4'hE, 130);
    hold(4'hF, 40);

    // randomized activity: short bursts act as bounces, long ones as presses
    cur = '1;
    for (int c = 0; c < N; c++) left[c] = int'($urandom_range(1, 40));
    for (int t = 0; t < 2500; t++) begin
      if (t == 1200) begin
        assert_reset();
        hold(cur, 3);
        release_reset();
      end
      for (int c = 0; c < N; c++) begin
        if (left[c] == 0) begin
          cur[c]  = ~cur[c];
          left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9))
                                                : int'($urandom_range(10, 140));
        end
        left[c]--;
      end
      drive(cur);
    end

    hold(4'hF, 100);
    done = 1'b1;
  end

endmodule
